srl_fifo_hs: RTL and testbench
==============================

Name: srl_fifo_hs

Overview:
- Parametrised SRL-based FIFO with full handshake. Successor to the fixed 1-bit, depth-6 start-token shift register.
- Wraps a generic shift-register storage array and adds occupancy tracking, full/empty and almost-full/almost-empty flags, a high-watermark register, and sticky overflow/underflow error flags.
- Used for start tokens and narrow data streams between HLS dataflow processes, e.g. between the Linear_Layer loaders and the PE array.

Parameters:
- DATA_WIDTH, 1, width of each stored word.
- DEPTH, 6, number of entries; legal range is 2 or more.
- ADDR_WIDTH, 3, read-address width; must satisfy 2^ADDR_WIDTH >= DEPTH. Checked by an elaboration assertion.
- AF_THRESH, DEPTH-1, almost_full is asserted when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty is asserted when count <= AE_THRESH.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_write_ce  in  1  write-side clock enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high while the FIFO has space.
- if_almost_full  out  1  count >= AF_THRESH.
- if_read_ce  in  1  read-side clock enable.
- if_read  in  1  read request (pop).
- if_dout  out  DATA_WIDTH  head-of-queue data (show-ahead).
- if_empty_n  out  1  high while data is present.
- if_almost_empty  out  1  count <= AE_THRESH.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.
- high_water  out  ADDR_WIDTH+1  maximum occupancy since reset or since clr_stats.
- clr_stats  in  1  synchronous clear of high_water, ovf and udf.
- ovf  out  1  sticky: a write was attempted while full.
- udf  out  1  sticky: a read was attempted while empty.

Behaviour:
- Handshake qualifiers:
  - push = if_write_ce & if_write & if_full_n
  - pop = if_read_ce & if_read & if_empty_n
- Storage:
  - On push, all entries shift by one and entry 0 takes if_din.
  - No clock enable is applied to storage except on push.
  - Contents are not reset.
- Read address is count-1 when count > 0, and 0 otherwise.
  - if_dout = SRL[addr], combinational from registered addr.
  - if_dout is the oldest word; the value when empty is don't-care.
- Count update (registered):
  - push only: count +1.
  - pop only: count -1.
  - push and pop together: count unchanged, addr unchanged. The new word enters at entry 0 and the head moves forward.
- Flags are registered and derived from the next count, so they are valid in the same cycle as count:
  - if_empty_n = (count != 0)
  - if_full_n = (count != DEPTH)
  - if_almost_full and if_almost_empty per their thresholds.
- Latency:
  - A push at edge t makes if_empty_n=1 and if_dout valid after edge t.
  - A pop frees space: if_full_n rises after the same edge.
- At full:
  - A write is refused even if a read occurs in the same cycle (no write-through at full). This matches HLS FIFO semantics.
  - The refused write sets ovf=1 when if_write_ce & if_write.
- At empty: a read sets udf=1 when if_read_ce & if_read. Count never underflows.
- high_water updates to next_count whenever next_count > high_water.
- clr_stats:
  - Clears high_water to the current count, and clears ovf and udf.
  - If an error occurs in the same cycle as clr_stats, the flag is set (set wins).
- Reset values:
  - count=0, addr=0
  - if_empty_n=0, if_full_n=1
  - if_almost_empty=1, if_almost_full=(AF_THRESH==0)
  - high_water=0, ovf=0, udf=0
- Reset asserted mid-operation discards occupancy immediately at the next edge. Pushes and pops in that cycle are ignored.
- if_fifo_cap is a tie-off to DEPTH.

Decomposition:
- Shared package srl_fifo_pkg contains:
  - a clog2 function
  - a count-width helper (clog2(DEPTH+1))
  - a localparam for the default start-token depth (6)
- One sub-module, srl_fifo_hs_shiftreg:
  - Ports: clk, we, addr, din, dout.
  - Parameters: DATA_WIDTH, ADDR_WIDTH, DEPTH.
  - Pure storage with no reset.
  - The top level holds all control.

Test Plan:
Defaults for all scenarios: DATA_WIDTH=8, DEPTH=6, AF_THRESH=5, AE_THRESH=1.
1. Reset, then push 0x11..0x16 on six consecutive cycles → count reaches 6, if_full_n=0 after the 6th edge, if_almost_full=1 after the 5th edge, if_dout=0x11 throughout.
2. From full, pop six times → if_dout sequence 0x11,0x12..0x16, if_empty_n=0 after the 6th pop, if_almost_empty=1 when count=1, high_water=6.
3. count=3, push 0xA0 and pop in the same cycle for 10 cycles → count stays 3, if_dout walks through the stored order and then 0xA0 values, no flag changes.
4. Full, assert write and read together → read accepted, write refused, count=5, ovf=1. clr_stats next cycle → ovf=0, high_water=5.
5. Empty, assert if_read with if_read_ce=1 → udf=1, count stays 0. With if_read_ce=0 → udf stays 0.
6. count=4, assert reset while pushing → after the edge count=0, if_empty_n=0, if_full_n=1, high_water=0. The next push of 0x5A yields if_dout=0x5A.

Source files
------------

// File: rtl/srl_fifo_pkg.sv
// Shared definitions for the SRL-based handshake FIFO: sizing helpers,
// the start-token default depth and the per-cycle operation encoding.
package srl_fifo_pkg;

  localparam int START_TOKEN_DEPTH = 6;

  // {push, pop} as seen by the occupancy counter
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // bits needed to hold an occupancy of 0..depth
  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/srl_fifo_hs_if.sv
// Write/read handshake and occupancy bundle of the SRL FIFO.
// slave = the FIFO itself, master = the process feeding and draining it.
interface srl_fifo_hs_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 3
) ();

  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_almost_full;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic                  if_almost_empty;
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic [ADDR_WIDTH:0]   if_fifo_cap;

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_almost_full, if_dout, if_empty_n, if_almost_empty,
           if_num_data_valid, if_fifo_cap
  );

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_almost_full, if_dout, if_empty_n, if_almost_empty,
           if_num_data_valid, if_fifo_cap
  );

endinterface

// File: rtl/srl_fifo_hs_shiftreg.sv
// Pure shift-register storage: entry 0 takes din on we, everything else
// moves up one slot. Read is an asynchronous mux, so it maps onto SRL primitives.
module srl_fifo_hs_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[0] <= din;

  for (genvar i = 1; i < DEPTH; i++) begin : g_stage
    always_ff @(posedge clk)
      if (we) mem[i] <= mem[i-1];
  end

  assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_hs.sv
// SRL FIFO with show-ahead read, registered occupancy flags, a high-watermark
// and sticky overflow/underflow bits. Storage lives in srl_fifo_hs_shiftreg.
module srl_fifo_hs
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = START_TOKEN_DEPTH,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                clk,
  input  logic                reset,
  srl_fifo_hs_if.slave        fifo,
  input  logic                clr_stats,
  output logic [ADDR_WIDTH:0] high_water,
  output logic                ovf,
  output logic                udf
);

  localparam int CW = ADDR_WIDTH + 1;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("srl_fifo_hs: DEPTH must be at least 2");
  end
  if ((1 << ADDR_WIDTH) < DEPTH) begin : g_bad_addr
    $error("srl_fifo_hs: ADDR_WIDTH too narrow for DEPTH");
  end
  if (CW < cnt_width(DEPTH)) begin : g_bad_cnt
    $error("srl_fifo_hs: occupancy counter too narrow for DEPTH");
  end

  cnt_t     count, next_count, hw_base, next_hw;
  addr_t    addr, next_addr;
  logic     wr_req, rd_req, push, pop;
  fifo_op_e op;

  always_comb begin
    wr_req     = fifo.if_write_ce & fifo.if_write;
    rd_req     = fifo.if_read_ce & fifo.if_read;
    // full refuses the write even if a pop frees a slot this cycle
    push       = wr_req & fifo.if_full_n;
    pop        = rd_req & fifo.if_empty_n;
    op         = fifo_op_e'({push, pop});
    next_count = count;
    case (op)
      OP_PUSH: next_count = count + cnt_t'(1);
      OP_POP:  next_count = count - cnt_t'(1);
      default: next_count = count;
    endcase
    next_addr  = (next_count == '0) ? '0 : addr_t'(next_count - cnt_t'(1));
    // clr_stats restarts the watermark from the occupancy it sees now
    hw_base    = clr_stats ? count : high_water;
    next_hw    = (next_count > hw_base) ? next_count : hw_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count                <= '0;
      addr                 <= '0;
      fifo.if_empty_n      <= 1'b0;
      fifo.if_full_n       <= 1'b1;
      fifo.if_almost_empty <= 1'b1;
      fifo.if_almost_full  <= (AF_THRESH == 0);
      high_water           <= '0;
      ovf                  <= 1'b0;
      udf                  <= 1'b0;
    end else begin
      count                <= next_count;
      addr                 <= next_addr;
      fifo.if_empty_n      <= (next_count != '0);
      fifo.if_full_n       <= (next_count != DEPTH_C);
      fifo.if_almost_empty <= (next_count <= AE_C);
      fifo.if_almost_full  <= (next_count >= AF_C);
      high_water           <= next_hw;
      // a new error in the clearing cycle still sets the flag
      ovf                  <= (ovf & ~clr_stats) | (wr_req & ~fifo.if_full_n);
      udf                  <= (udf & ~clr_stats) | (rd_req & ~fifo.if_empty_n);
    end
  end

  assign fifo.if_num_data_valid = count;
  assign fifo.if_fifo_cap       = DEPTH_C;

  srl_fifo_hs_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push & ~reset),
    .addr (addr),
    .din  (fifo.if_din),
    .dout (fifo.if_dout)
  );

endmodule

// File: tb/tb_srl_fifo_hs.sv
// Scoreboard bench for srl_fifo_hs: a queue-based FIFO model predicts each
// cycle's outcome; a monitor compares the DUT one step after every edge.
module tb_srl_fifo_hs;

  localparam int DW = 8;
  localparam int DEPTH = 6;
  localparam int AW = 3;
  localparam int AF = 5;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_stats = 1'b0;
  logic [AW:0] high_water;
  logic ovf, udf;

  always #5 clk = ~clk;

  srl_fifo_hs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo ();

  srl_fifo_hs #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo       (fifo.slave),
    .clr_stats  (clr_stats),
    .high_water (high_water),
    .ovf        (ovf),
    .udf        (udf)
  );

  typedef struct {
    int       cnt;
    bit [7:0] head;
    int       hw;
    bit       ovf;
    bit       udf;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] mdl_q[$];
  int       mdl_hw;
  bit       mdl_ovf, mdl_udf;
  int       n_cmp = 0;
  int       n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // monitor: every edge the DUT presents a new state, compare with the next prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count",        32'(fifo.if_num_data_valid), 32'(e.cnt));
      chk("empty_n",      32'(fifo.if_empty_n),        32'(e.cnt != 0));
      chk("full_n",       32'(fifo.if_full_n),         32'(e.cnt != DEPTH));
      chk("almost_full",  32'(fifo.if_almost_full),    32'(e.cnt >= AF));
      chk("almost_empty", 32'(fifo.if_almost_empty),   32'(e.cnt <= AE));
      chk("high_water",   32'(high_water),             32'(e.hw));
      chk("ovf",          32'(ovf),                    32'(e.ovf));
      chk("udf",          32'(udf),                    32'(e.udf));
      chk("fifo_cap",     32'(fifo.if_fifo_cap),       32'(DEPTH));
      if (e.cnt != 0) chk("dout", 32'(fifo.if_dout), 32'(e.head));
    end
  end

  // one clock of stimulus; the model is a plain queue of words
  task automatic step(input bit wce, input bit w, input bit [7:0] d,
                      input bit rce, input bit r, input bit clr, input bit rst);
    exp_t e;
    bit   wr, rd, full, empty;
    int   old, base;
    @(negedge clk);
    fifo.if_write_ce = wce; fifo.if_write = w; fifo.if_din = d;
    fifo.if_read_ce = rce;  fifo.if_read = r;
    clr_stats = clr; reset = rst;
    wr = wce && w; rd = rce && r;
    if (rst) begin
      mdl_q.delete(); mdl_hw = 0; mdl_ovf = 0; mdl_udf = 0;
    end else begin
      old   = mdl_q.size();
      full  = (old == DEPTH);
      empty = (old == 0);
      if (rd && !empty) void'(mdl_q.pop_front());
      if (wr && !full) mdl_q.push_back(d);
      base    = clr ? old : mdl_hw;
      mdl_hw  = (mdl_q.size() > base) ? mdl_q.size() : base;
      mdl_ovf = (mdl_ovf && !clr) || (wr && full);
      mdl_udf = (mdl_udf && !clr) || (rd && empty);
    end
    e.cnt  = mdl_q.size();
    e.head = (mdl_q.size() > 0) ? mdl_q[0] : 8'h00;
    e.hw   = mdl_hw;
    e.ovf  = mdl_ovf;
    e.udf  = mdl_udf;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    fifo.if_write_ce = 0; fifo.if_write = 0; fifo.if_din = '0;
    fifo.if_read_ce = 0;  fifo.if_read = 0;

    // 1: reset, then fill with 0x11..0x16
    step(0, 0, 8'h00, 0, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h11 + i), 0, 0, 0, 0);
    // 2: drain in order
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 1, 0, 0);
    idle();
    // 3: count=3, simultaneous push/pop for 10 cycles
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h31 + i), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 8'hA0, 1, 1, 0, 0);
    // 4: full, write+read together, then clr_stats
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h41 + i), 0, 0, 0, 0);
    step(1, 1, 8'hEE, 1, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    idle();
    // 5: underflow only with read_ce
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0, 0);
    step(0, 0, 8'h00, 1, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    // 6: reset while pushing at count=4
    for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h61 + i), 0, 0, 0, 0);
    step(1, 1, 8'h77, 0, 0, 0, 1);
    step(1, 1, 8'h5A, 0, 0, 0, 0);
    idle();

    // randomized traffic with occasional stats clear and reset
    for (int i = 0; i < 2000; i++) begin
      step(bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 199) == 0));
    end
    idle();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
